// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int MAX_WIDTH = 32;
  localparam int CNT_W     = $clog2(MAX_WIDTH);

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// One-bit full adder; the only arithmetic element in the serial adder datapath.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ cin;
  assign co = (a & b) | (cin & p);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: {cout,sum} = a + b + cin over WIDTH cycles, LSB first.
// Optional signed-overflow output is enabled by defining SERIAL_ADDER_OVF_EN.
//
// state | meaning
// IDLE  | waiting for start; operands captured when start is seen
// RUN   | one sum bit per cycle, WIDTH cycles total
// DONE  | one-cycle done pulse, result already on sum/cout
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  // Holds the WIDTH-1 bits produced so far; the last bit joins it directly at the output.
  logic [WIDTH-2:0] sum_sr_q, sum_sr_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] sum_cat;

  full_adder_cell u_fa (
    .a   (a_sr_q[0]),
    .b   (b_sr_q[0]),
    .cin (carry_q),
    .s   (fa_s),
    .co  (fa_co)
  );

  assign sum_cat = {fa_s, sum_sr_q};

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d    = ovf_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d   = a;
          b_sr_d   = b;
          sum_sr_d = '0;
          carry_d  = cin;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
        sum_sr_d = sum_cat[WIDTH-1:1];
        carry_d  = fa_co;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          sum_d   = sum_cat;
          cout_d  = fa_co;
`ifdef SERIAL_ADDER_OVF_EN
          // carry_q is the carry into the MSB during the final bit.
          ovf_d   = carry_q ^ fa_co;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial ripple adder: it adds two WIDTH-bit operands plus a carry-in over WIDTH clock cycles, one bit per cycle, LSB first. It uses a single 1-bit full-adder cell and a carry flip-flop. It is the addition counterpart to the team's full-subtractor datapath and serves area-constrained arithmetic paths. Operands are loaded in parallel and the result is returned in parallel with a done pulse.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 2..32).

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  operand A, captured on accepted start
b  input  WIDTH  operand B, captured on accepted start
cin  input  1  carry-in, captured on accepted start
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse when sum/cout are valid
sum  output  WIDTH  result; holds until the next accepted start
cout  output  1  final carry-out; holds with sum

Behaviour:
- Reset (rst high at a clk edge): state=IDLE, busy=0, done=0, sum=0, cout=0, bit counter=0, carry FF=0, operand shift registers=0. Reset wins over every other event, including mid-RUN; a partial result is discarded.
- States: IDLE, RUN, DONE.
- IDLE: busy=0, done=0.
  - If start=1 at edge T: latch a and b into shift registers, carry<=cin, count<=0, go to RUN.
  - Otherwise remain in IDLE.
- RUN: busy=1. Each edge does the following:
  - Bit i is computed by the full-adder cell from the operand LSBs and carry.
  - The sum bit shifts into the MSB of the sum shift register; both operand registers shift right.
  - carry<=cell carry-out; count++.
  - When count==WIDTH-1 at the edge, go to DONE.
  - RUN lasts exactly WIDTH cycles.
- DONE: busy=1, done=1 for exactly one cycle. The sum register holds the full result and cout=carry. The next edge goes to IDLE.
- Latency: start sampled at edge T gives done high during the cycle after edge T+WIDTH, i.e. it is observed at edge T+WIDTH+1.
- Throughput: one operation per WIDTH+2 cycles. Back-to-back starts are accepted only after returning to IDLE.
- start while busy (RUN or DONE): ignored, with no effect on operands or the result.
- sum/cout output registers update only at the RUN->DONE transition. Intermediate shifting is internal, so outputs never show partial values.
- Arithmetic: {cout,sum} = a + b + cin, unsigned, modulo 2^(WIDTH+1). No saturation.
- a, b and cin changing after start is accepted: no effect.

Optional Feature:
Macro SERIAL_ADDER_OVF_EN.
- Defined: adds output port ovf (1 bit), reset 0, updated with sum/cout. ovf = carry into MSB XOR carry out of MSB (two's-complement signed overflow). A 1-bit register captures the carry-in of the final RUN cycle.
- Undefined: the ovf port and its register are absent; all other behaviour is identical.

Decomposition:
- Package serial_adder_pkg holds:
  - the state typedef (enum: IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the counter width constant, derived as clog2 of the maximum WIDTH (32 -> 5 bits).
- Sub-module full_adder_cell is natural: combinational a, b, cin -> s, co, instantiated once in RUN's datapath. It is reusable by other arithmetic blocks.

Test Plan:
1. WIDTH=8: start at T with a=0x5A, b=0x33, cin=0 -> done at T+9, sum=0x8D, cout=0; busy high T+1..T+9.
2. a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1.
3. start=1 held continuously with a=0x01, b=0x01 -> ops complete at done pulses spaced 10 cycles apart, sum=0x02 each time.
4. Start op a=0x10, b=0x20; at T+3 drive start with a=0xFF, b=0xFF -> ignored; done at T+9 with sum=0x30, cout=0.
5. Start op, assert rst at T+4 -> next cycle state IDLE, busy=0, sum=0, cout=0; no done pulse. A new start afterwards completes correctly.
6. SERIAL_ADDER_OVF_EN defined: a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1. Then a=0xFF, b=0x01 -> sum=0x00, cout=1, ovf=0.
